// File: rtl/fifo_burst_pkg.sv
// Shared types and default widths for the FIFO burst drain engine.
package fifo_burst_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_LEN_WIDTH  = 8;
  localparam int unsigned DEF_CNT_WIDTH  = 16;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    CAPTURE = 3'd2,
    SEND    = 3'd3,
    FINISH  = 3'd4
  } state_e;

endpackage

// File: rtl/fifo_burst_drain.sv
// Drains an upstream synchronous FIFO in length-programmed bursts onto a
// valid/ready stream, flagging the last beat and counting completed bursts.
module fifo_burst_drain
  import fifo_burst_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned LEN_WIDTH  = DEF_LEN_WIDTH,
  parameter int unsigned CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  burst_len,
  input  logic                  abort,
  output logic                  fifo_rd_en,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  burst_count
);

  state_e                r_state, w_state;
  logic [LEN_WIDTH-1:0]  r_len, w_len;
  logic [LEN_WIDTH-1:0]  r_beat, w_beat;
  logic                  r_aborted, w_aborted;
  logic                  r_valid, w_valid;
  logic                  r_last, w_last;
  logic [DATA_WIDTH-1:0] r_data, w_data;
  logic                  r_busy, w_busy;
  logic                  r_done, w_done;
  logic [CNT_WIDTH-1:0]  r_count, w_count;
  logic                  w_hs;

  assign w_hs = r_valid && out_ready;

  // Next-state and datapath update; fifo_rd_en is the one combinational output.
  always_comb begin
    w_state    = r_state;
    w_len      = r_len;
    w_beat     = r_beat;
    w_aborted  = r_aborted;
    w_valid    = r_valid;
    w_last     = r_last;
    w_data     = r_data;
    w_count    = r_count;
    w_done     = 1'b0;
    fifo_rd_en = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_len   = burst_len;
          w_beat  = '0;
          w_state = (burst_len == '0) ? FINISH : FETCH;
        end
      end
      FETCH: begin
        if (abort) begin
          w_aborted = 1'b1;
          w_state   = FINISH;
        end else begin
          fifo_rd_en = !fifo_empty;
          if (!fifo_empty) w_state = CAPTURE;
        end
      end
      CAPTURE: begin
        // FIFO output moves on while we wait in SEND, so hold our own copy.
        w_data  = fifo_data;
        w_valid = 1'b1;
        w_last  = (r_beat == r_len - LEN_WIDTH'(1));
        w_state = SEND;
      end
      SEND: begin
        if (w_hs) begin
          w_valid = 1'b0;
          w_beat  = r_beat + LEN_WIDTH'(1);
          w_state = r_last ? FINISH : FETCH;
        end
      end
      FINISH: begin
        w_done = 1'b1;
        if (!r_aborted && (r_len != '0)) w_count = r_count + CNT_WIDTH'(1);
        w_last    = 1'b0;
        w_aborted = 1'b0;
        w_state   = IDLE;
      end
      default: w_state = IDLE;
    endcase
    w_busy = (w_state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_len     <= '0;
      r_beat    <= '0;
      r_aborted <= 1'b0;
      r_valid   <= 1'b0;
      r_last    <= 1'b0;
      r_data    <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_count   <= '0;
    end else begin
      r_len     <= w_len;
      r_beat    <= w_beat;
      r_aborted <= w_aborted;
      r_valid   <= w_valid;
      r_last    <= w_last;
      r_data    <= w_data;
      r_busy    <= w_busy;
      r_done    <= w_done;
      r_count   <= w_count;
    end
  end

  assign out_valid   = r_valid;
  assign out_data    = r_data;
  assign out_last    = r_last;
  assign busy        = r_busy;
  assign done        = r_done;
  assign burst_count = r_count;

endmodule

// File: tb/tb_fifo_burst_drain.sv
// Bench for fifo_burst_drain: behavioural 8-deep FIFO upstream, queue-based
// reference of burst contents, table vectors, directed corners and random bursts.
module tb_fifo_burst_drain;

  localparam int unsigned DW = 8;
  localparam int unsigned LW = 8;
  localparam int unsigned CW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [LW-1:0] burst_len = '0;
  logic          fifo_rd_en;
  logic          fifo_empty = 1'b1;
  logic [DW-1:0] fifo_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          busy;
  logic          done;
  logic [CW-1:0] burst_count;

  logic       push_req = 1'b0;
  logic [7:0] push_data = '0;
  logic [7:0] fq[$];
  logic [7:0] mdl_q[$];
  logic [8:0] obs_q[$];

  int n_checks = 0, n_err = 0;
  int cyc = 0, done_cnt = 0, done_cyc = 0, rd_cnt = 0, rd_viol = 0, stab_viol = 0;
  int start_cyc = 0, done_base = 0, rd_base = 0, exp_count = 0;
  logic [7:0] next_word = 8'h11;
  logic [7:0] lost;

  logic       p_valid = 1'b0, p_hs = 1'b0, p_last = 1'b0;
  logic [7:0] p_data = '0;

  typedef struct {
    logic [7:0] len;
    int         n_pre;
    int         exp_lat;
    int         exp_beats;
    int         cnt_inc;
  } vec_t;
  vec_t vecs[6];

  fifo_burst_drain dut (
    .clk(clk), .rst(rst), .start(start), .burst_len(burst_len), .abort(abort),
    .fifo_rd_en(fifo_rd_en), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .done(done), .burst_count(burst_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Upstream FIFO: registered data_out, refreshed to the head whenever non-empty.
  always @(posedge clk) begin
    if (fifo_rd_en && fq.size() > 0) fifo_data <= fq.pop_front();
    else if (fq.size() > 0)          fifo_data <= fq[0];
    if (push_req && fq.size() < 8) fq.push_back(push_data);
    fifo_empty <= (fq.size() == 0);
  end

  // Stream monitor sampled mid-cycle.
  always @(negedge clk) begin
    if (out_valid && out_ready) obs_q.push_back({out_last, out_data});
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
    if (fifo_rd_en) rd_cnt <= rd_cnt + 1;
    if (fifo_rd_en && (fifo_empty || out_valid)) rd_viol <= rd_viol + 1;
    if (p_valid && !p_hs && out_valid && ({out_last, out_data} != {p_last, p_data}))
      stab_viol <= stab_viol + 1;
    p_valid <= out_valid;
    p_hs    <= out_valid && out_ready;
    p_last  <= out_last;
    p_data  <= out_data;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [7:0] w);
    push_req  = 1'b1;
    push_data = w;
    mdl_q.push_back(w);
    tick();
    push_req = 1'b0;
  endtask

  task automatic do_start(input logic [7:0] len);
    burst_len = len;
    start     = 1'b1;
    done_base = done_cnt;
    tick();
    start     = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (done_cnt == done_base && n < budget) begin
      tick();
      n++;
    end
    check({tag, " done seen"}, 32'(done_cnt != done_base), 32'd1);
  endtask

  task automatic wait_obs(input string tag, input int need, input int budget);
    int n = 0;
    while (obs_q.size() < need && n < budget) begin
      tick();
      n++;
    end
    check({tag, " beat seen"}, 32'(obs_q.size() >= need), 32'd1);
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int n = 0;
    while (!out_valid && n < budget) begin
      tick();
      n++;
    end
    check({tag, " valid seen"}, 32'(out_valid), 32'd1);
  endtask

  // Expected beats are the next n words the model FIFO holds, in push order.
  task automatic check_burst(input string tag, input int n, input logic full);
    logic [7:0] e;
    logic [8:0] o;
    check({tag, " nbeats"}, 32'(obs_q.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      e = (mdl_q.size() > 0) ? mdl_q.pop_front() : 8'h00;
      if (obs_q.size() > 0) begin
        o = obs_q.pop_front();
        check({tag, " data"}, 32'(o[7:0]), 32'(e));
        check({tag, " last"}, 32'(o[8]), 32'(full && (i == n - 1)));
      end
    end
    obs_q.delete();
  endtask

  initial begin
    int len, npre, rem, n;
    vecs[0] = '{8'd4, 4, 13, 4, 1};
    vecs[1] = '{8'd1, 1, 4, 1, 1};
    vecs[2] = '{8'd0, 0, 1, 0, 0};
    vecs[3] = '{8'd3, 5, 10, 3, 1};
    vecs[4] = '{8'd2, 0, 7, 2, 1};
    vecs[5] = '{8'd8, 8, 25, 8, 1};

    repeat (3) tick();
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst out_last", 32'(out_last), 32'd0);
    check("rst out_data", 32'(out_data), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst burst_count", 32'(burst_count), 32'd0);
    check("rst rd_en", 32'(fifo_rd_en), 32'd0);
    rst = 1'b0;
    tick();

    for (int t = 0; t < 6; t++) begin
      for (int k = 0; k < vecs[t].n_pre; k++) begin
        push_word(next_word);
        next_word++;
      end
      rd_base = rd_cnt;
      do_start(vecs[t].len);
      wait_done("vec", 200);
      check("vec latency", 32'(done_cyc - start_cyc), 32'(vecs[t].exp_lat));
      tick();
      tick();
      check("vec done pulses", 32'(done_cnt - done_base), 32'd1);
      check("vec busy", 32'(busy), 32'd0);
      check("vec reads", 32'(rd_cnt - rd_base), 32'(vecs[t].exp_beats));
      check_burst("vec", vecs[t].exp_beats, 1'b1);
      exp_count += vecs[t].cnt_inc;
      check("vec burst_count", 32'(burst_count), 32'(exp_count));
      check("vec fifo_empty", 32'(fifo_empty), 32'(mdl_q.size() == 0));
    end

    rd_base = rd_cnt;
    do_start(8'd2);
    repeat (10) tick();
    check("empty no read", 32'(rd_cnt - rd_base), 32'd0);
    check("empty busy", 32'(busy), 32'd1);
    check("empty no beat", 32'(obs_q.size()), 32'd0);
    push_word(8'hA5);
    repeat (5) tick();
    push_word(8'h5A);
    wait_done("empty", 100);
    check_burst("empty", 2, 1'b1);
    exp_count++;
    check("empty burst_count", 32'(burst_count), 32'(exp_count));

    for (int k = 0; k < 3; k++) push_word(8'hC0 + 8'(k));
    do_start(8'd3);
    wait_obs("bp", 1, 50);
    out_ready = 1'b0;
    wait_valid("bp", 50);
    rd_base = rd_cnt;
    repeat (5) tick();
    check("bp fifo level", 32'(fq.size()), 32'd1);
    check("bp no read", 32'(rd_cnt - rd_base), 32'd0);
    check("bp valid held", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    wait_done("bp", 100);
    check_burst("bp", 3, 1'b1);
    exp_count++;
    check("bp burst_count", 32'(burst_count), 32'(exp_count));
    check("bp stable", 32'(stab_viol), 32'd0);

    for (int k = 0; k < 4; k++) push_word(8'hD0 + 8'(k));
    do_start(8'd4);
    wait_obs("abort", 2, 50);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    wait_done("abort", 50);
    check_burst("abort", 2, 1'b0);
    check("abort burst_count", 32'(burst_count), 32'(exp_count));
    check("abort fifo level", 32'(fq.size()), 32'(mdl_q.size()));
    do_start(8'd2);
    wait_done("post abort", 50);
    check_burst("post abort", 2, 1'b1);
    exp_count++;
    check("post abort count", 32'(burst_count), 32'(exp_count));

    for (int k = 0; k < 3; k++) push_word(8'hE0 + 8'(k));
    do_start(8'd3);
    wait_obs("rst mid", 1, 50);
    out_ready = 1'b0;
    wait_valid("rst mid", 50);
    tick();
    rst = 1'b1;
    tick();
    check("rst mid out_valid", 32'(out_valid), 32'd0);
    check("rst mid busy", 32'(busy), 32'd0);
    check("rst mid burst_count", 32'(burst_count), 32'd0);
    check("rst mid out_last", 32'(out_last), 32'd0);
    rst = 1'b0;
    exp_count = 0;
    check_burst("rst mid", 1, 1'b0);
    lost = mdl_q.pop_front();
    out_ready = 1'b1;
    tick();
    do_start(8'd1);
    wait_done("post rst", 50);
    check_burst("post rst", 1, 1'b1);
    exp_count++;
    check("post rst count", 32'(burst_count), 32'(exp_count));

    for (int it = 0; it < 25; it++) begin
      len  = int'($urandom_range(0, 6));
      npre = int'($urandom_range(0, len));
      for (int k = 0; k < npre; k++) push_word(8'($urandom));
      rem = len - npre;
      do_start(8'(len));
      n = 0;
      while (done_cnt == done_base && n < 400) begin
        out_ready = ($urandom % 4) != 0;
        if (rem > 0 && ($urandom % 3) == 0) begin
          push_req  = 1'b1;
          push_data = 8'($urandom);
          mdl_q.push_back(push_data);
          rem--;
        end else begin
          push_req = 1'b0;
        end
        tick();
        n++;
      end
      push_req  = 1'b0;
      out_ready = 1'b1;
      check("rnd done seen", 32'(done_cnt != done_base), 32'd1);
      tick();
      check_burst("rnd", len, 1'b1);
      if (len != 0) exp_count++;
      check("rnd burst_count", 32'(burst_count), 32'(exp_count));
    end

    check("read while empty or busy", 32'(rd_viol), 32'd0);
    check("output stability", 32'(stab_viol), 32'd0);
    check("final fifo level", 32'(fq.size()), 32'(mdl_q.size()));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
